// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control sequencer: op codes, FSM states, select indices and the
// registered strobe bundle.
package alu_ctrl_pkg;

  localparam logic [2:0] OP_ADC  = 3'b000;
  localparam logic [2:0] OP_SBC  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_EOR  = 3'b011;
  localparam logic [2:0] OP_ORA  = 3'b100;
  localparam logic [2:0] OP_LSR  = 3'b101;
  localparam logic [2:0] OP_ROR  = 3'b110;
  localparam logic [2:0] OP_ADDR = 3'b111;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD_A = 3'd1;
  localparam logic [2:0] ST_LOAD_B = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_HOLD   = 3'd4;
  localparam logic [2:0] ST_WRITE  = 3'd5;

  localparam int unsigned SEL_SUMS = 0;
  localparam int unsigned SEL_ANDS = 1;
  localparam int unsigned SEL_EORS = 2;
  localparam int unsigned SEL_ORS  = 3;
  localparam int unsigned SEL_SRS  = 4;
  localparam int unsigned NUM_SEL  = 5;

  localparam int unsigned LDB_DB     = 0;
  localparam int unsigned LDB_NOT_DB = 1;
  localparam int unsigned LDB_ADL    = 2;
  localparam int unsigned NUM_LDB    = 3;

  typedef struct packed {
    logic sb_to_a;
    logic db_to_b;
    logic not_db_to_b;
    logic adl_to_b;
    logic sums;
    logic ands;
    logic eors;
    logic ors;
    logic srs;
    logic carry_in;
    logic daa;
    logic alu_to_hold;
    logic hold_to_adl;
    logic hold_l_to_sb;
    logic done;
    logic busy;
  } strobe_t;

  function automatic logic is_shift(logic [2:0] op);
    return (op == OP_LSR) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational op decode: operand-B source, function select, carry source and write-back target.
module alu_op_decode
  import alu_ctrl_pkg::*;
(
  input  logic [2:0]         op_i,
  output logic [NUM_LDB-1:0] load_b_o,
  output logic [NUM_SEL-1:0] sel_o,
  output logic               carry_from_flag_o,
  output logic               wb_adl_o,
  output logic               skip_b_o,
  output logic               decimal_o
);

  always_comb begin
    load_b_o          = '0;
    sel_o             = '0;
    carry_from_flag_o = 1'b0;
    wb_adl_o          = 1'b0;
    decimal_o         = 1'b0;
    skip_b_o          = is_shift(op_i);
    unique case (op_i)
      OP_ADC: begin
        load_b_o[LDB_DB]  = 1'b1;
        sel_o[SEL_SUMS]   = 1'b1;
        carry_from_flag_o = 1'b1;
        decimal_o         = 1'b1;
      end
      OP_SBC: begin
        load_b_o[LDB_NOT_DB] = 1'b1;
        sel_o[SEL_SUMS]      = 1'b1;
        carry_from_flag_o    = 1'b1;
        decimal_o            = 1'b1;
      end
      OP_AND: begin
        load_b_o[LDB_DB] = 1'b1;
        sel_o[SEL_ANDS]  = 1'b1;
      end
      OP_EOR: begin
        load_b_o[LDB_DB] = 1'b1;
        sel_o[SEL_EORS]  = 1'b1;
      end
      OP_ORA: begin
        load_b_o[LDB_DB] = 1'b1;
        sel_o[SEL_ORS]   = 1'b1;
      end
      OP_LSR: sel_o[SEL_SRS] = 1'b1;
      OP_ROR: begin
        sel_o[SEL_SRS]    = 1'b1;
        carry_from_flag_o = 1'b1;
      end
      OP_ADDR: begin
        // Address add: carry forced low, result goes back on ADL.
        load_b_o[LDB_ADL] = 1'b1;
        sel_o[SEL_SUMS]   = 1'b1;
        wb_adl_o          = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_sequencer.sv
// ALU datapath control sequencer: one ALU operation per accepted request, registered strobes.
// Optional decimal-adjust support is enabled by defining ALU_DECIMAL_EN.
module alu_ctrl_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic [2:0] op,
  input  logic       c_flag,
  input  logic       d_flag,
  input  logic       ACR_OUT,
  input  logic       AVR_OUT,
  input  logic       HC_OUT,
  output logic       busy,
  output logic       done,
  output logic       acr,
  output logic       avr,
  output logic       hc,
  output logic       SB_TO_A,
  output logic       DB_TO_B,
  output logic       NOT_DB_TO_B,
  output logic       ADL_TO_B,
  output logic       sig_SUMS,
  output logic       sig_ANDS,
  output logic       sig_EORS,
  output logic       sig_ORS,
  output logic       sig_SRS,
  output logic       sig_CARRY_IN,
  output logic       sig_DAA,
  output logic       ALU_TO_HOLD,
  output logic       HOLD_TO_ADL,
  output logic       HOLD_L_TO_SB
);

  if (EXEC_CYCLES == 0 || EXEC_CYCLES > 4) begin : g_bad_exec_cycles
    $fatal(1, "alu_ctrl_sequencer: EXEC_CYCLES must be in 1..4");
  end

  localparam logic [1:0] LastCnt = 2'(EXEC_CYCLES - 1);

  logic [2:0] state_q, state_d, op_q, op_d;
  logic [1:0] cnt_q, cnt_d;
  logic       c_q, c_d, d_q, d_d;
  logic       acr_q, acr_d, avr_q, avr_d, hc_q, hc_d;
  strobe_t    strb_q, strb_d;

  logic [NUM_LDB-1:0] load_b;
  logic [NUM_SEL-1:0] sel;
  logic               carry_from_flag, wb_adl, skip_b, decimal, fn_active;

  // Decoded from next-state op so the strobes can be registered alongside the state.
  alu_op_decode u_decode (
    .op_i              (op_d),
    .load_b_o          (load_b),
    .sel_o             (sel),
    .carry_from_flag_o (carry_from_flag),
    .wb_adl_o          (wb_adl),
    .skip_b_o          (skip_b),
    .decimal_o         (decimal)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    d_d     = d_q;
    acr_d   = acr_q;
    avr_d   = avr_q;
    hc_d    = hc_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD_A;
          op_d    = op;
          c_d     = c_flag;
          d_d     = d_flag;
        end
      end
      ST_LOAD_A: begin
        state_d = is_shift(op_q) ? ST_EXEC : ST_LOAD_B;
        cnt_d   = '0;
      end
      ST_LOAD_B: begin
        state_d = ST_EXEC;
        cnt_d   = '0;
      end
      ST_EXEC: begin
        if (cnt_q == LastCnt) begin
          state_d = ST_HOLD;
          acr_d   = ACR_OUT;
          avr_d   = AVR_OUT;
`ifdef ALU_DECIMAL_EN
          hc_d    = HC_OUT;
`endif
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      ST_HOLD:  state_d = ST_WRITE;
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign fn_active = (state_d == ST_EXEC) || (state_d == ST_HOLD);

  always_comb begin
    strb_d              = '0;
    strb_d.sb_to_a      = (state_d == ST_LOAD_A);
    if (state_d == ST_LOAD_B) begin
      strb_d.db_to_b     = load_b[LDB_DB];
      strb_d.not_db_to_b = load_b[LDB_NOT_DB];
      strb_d.adl_to_b    = load_b[LDB_ADL];
    end
    if (fn_active) begin
      strb_d.sums     = sel[SEL_SUMS];
      strb_d.ands     = sel[SEL_ANDS];
      strb_d.eors     = sel[SEL_EORS];
      strb_d.ors      = sel[SEL_ORS];
      strb_d.srs      = sel[SEL_SRS];
      strb_d.carry_in = carry_from_flag & c_d;
`ifdef ALU_DECIMAL_EN
      strb_d.daa      = decimal & d_d;
`endif
    end
    strb_d.alu_to_hold  = (state_d == ST_HOLD);
    if (state_d == ST_WRITE) begin
      strb_d.hold_to_adl  = wb_adl;
      strb_d.hold_l_to_sb = ~wb_adl;
      strb_d.done         = 1'b1;
    end
    strb_d.busy         = (state_d != ST_IDLE);
  end

`ifndef ALU_DECIMAL_EN
  logic unused_dec;
  assign unused_dec = decimal ^ d_q ^ HC_OUT;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      d_q     <= 1'b0;
      acr_q   <= 1'b0;
      avr_q   <= 1'b0;
      hc_q    <= 1'b0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      d_q     <= d_d;
      acr_q   <= acr_d;
      avr_q   <= avr_d;
      hc_q    <= hc_d;
      strb_q  <= strb_d;
    end
  end

  assign busy         = strb_q.busy;
  assign done         = strb_q.done;
  assign acr          = acr_q;
  assign avr          = avr_q;
  assign hc           = hc_q;
  assign SB_TO_A      = strb_q.sb_to_a;
  assign DB_TO_B      = strb_q.db_to_b;
  assign NOT_DB_TO_B  = strb_q.not_db_to_b;
  assign ADL_TO_B     = strb_q.adl_to_b;
  assign sig_SUMS     = strb_q.sums;
  assign sig_ANDS     = strb_q.ands;
  assign sig_EORS     = strb_q.eors;
  assign sig_ORS      = strb_q.ors;
  assign sig_SRS      = strb_q.srs;
  assign sig_CARRY_IN = strb_q.carry_in;
  assign sig_DAA      = strb_q.daa;
  assign ALU_TO_HOLD  = strb_q.alu_to_hold;
  assign HOLD_TO_ADL  = strb_q.hold_to_adl;
  assign HOLD_L_TO_SB = strb_q.hold_l_to_sb;

endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
// Self-checking bench for alu_ctrl_sequencer: directed cases plus randomized ops against a
// phase-list reference model.
module tb_alu_ctrl_sequencer;

  localparam int EC = 1;
`ifdef ALU_DECIMAL_EN
  localparam bit DecEn = 1'b1;
`else
  localparam bit DecEn = 1'b0;
`endif

  localparam int PH_LA = 0;
  localparam int PH_LB = 1;
  localparam int PH_EX = 2;
  localparam int PH_HO = 3;
  localparam int PH_WR = 4;

  typedef struct packed {
    logic sb_to_a, db_to_b, not_db_to_b, adl_to_b;
    logic sums, ands, eors, ors, srs, carry_in, daa;
    logic alu_to_hold, hold_to_adl, hold_l_to_sb, done, busy;
  } obs_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic start = 1'b0;
  logic [2:0] op = 3'd0;
  logic c_flag = 1'b0, d_flag = 1'b0;
  logic ACR_OUT = 1'b0, AVR_OUT = 1'b0, HC_OUT = 1'b0;
  logic busy, done, acr, avr, hc;
  logic SB_TO_A, DB_TO_B, NOT_DB_TO_B, ADL_TO_B;
  logic sig_SUMS, sig_ANDS, sig_EORS, sig_ORS, sig_SRS, sig_CARRY_IN, sig_DAA;
  logic ALU_TO_HOLD, HOLD_TO_ADL, HOLD_L_TO_SB;

  int n_cmp = 0;
  int n_err = 0;
  logic [2:0] m_flags = 3'b000;  // model {acr, avr, hc}

  always #5 CLK = ~CLK;

  alu_ctrl_sequencer #(.EXEC_CYCLES(EC)) dut (
    .CLK(CLK), .RST(RST), .start(start), .op(op), .c_flag(c_flag), .d_flag(d_flag),
    .ACR_OUT(ACR_OUT), .AVR_OUT(AVR_OUT), .HC_OUT(HC_OUT),
    .busy(busy), .done(done), .acr(acr), .avr(avr), .hc(hc),
    .SB_TO_A(SB_TO_A), .DB_TO_B(DB_TO_B), .NOT_DB_TO_B(NOT_DB_TO_B), .ADL_TO_B(ADL_TO_B),
    .sig_SUMS(sig_SUMS), .sig_ANDS(sig_ANDS), .sig_EORS(sig_EORS), .sig_ORS(sig_ORS),
    .sig_SRS(sig_SRS), .sig_CARRY_IN(sig_CARRY_IN), .sig_DAA(sig_DAA),
    .ALU_TO_HOLD(ALU_TO_HOLD), .HOLD_TO_ADL(HOLD_TO_ADL), .HOLD_L_TO_SB(HOLD_L_TO_SB)
  );

  // Expected strobes for one cycle, straight from the per-phase rules.
  function automatic obs_t model(int ph, logic [2:0] o, logic c, logic d);
    obs_t e = '0;
    e.busy = 1'b1;
    case (ph)
      PH_LA: e.sb_to_a = 1'b1;
      PH_LB: begin
        if (o == 3'd1)      e.not_db_to_b = 1'b1;
        else if (o == 3'd7) e.adl_to_b = 1'b1;
        else                e.db_to_b = 1'b1;
      end
      PH_EX, PH_HO: begin
        e.sums     = (o == 3'd0) || (o == 3'd1) || (o == 3'd7);
        e.ands     = (o == 3'd2);
        e.eors     = (o == 3'd3);
        e.ors      = (o == 3'd4);
        e.srs      = (o == 3'd5) || (o == 3'd6);
        e.carry_in = c && ((o == 3'd0) || (o == 3'd1) || (o == 3'd6));
        e.daa      = DecEn && d && (o <= 3'd1);
        e.alu_to_hold = (ph == PH_HO);
      end
      default: begin
        e.hold_to_adl  = (o == 3'd7);
        e.hold_l_to_sb = (o != 3'd7);
        e.done         = 1'b1;
      end
    endcase
    return e;
  endfunction

  task automatic check_cycle(input string tag, input obs_t exp);
    obs_t ob;
    logic [2:0] fl;
    ob = {SB_TO_A, DB_TO_B, NOT_DB_TO_B, ADL_TO_B, sig_SUMS, sig_ANDS, sig_EORS, sig_ORS,
          sig_SRS, sig_CARRY_IN, sig_DAA, ALU_TO_HOLD, HOLD_TO_ADL, HOLD_L_TO_SB, done, busy};
    fl = {acr, avr, hc};
    n_cmp++;
    assert (ob === exp) else begin
      n_err++;
      $error("FAIL %s strobes: observed %h, expected %h", tag, ob, exp);
    end
    n_cmp++;
    assert (fl === m_flags) else begin
      n_err++;
      $error("FAIL %s flags: observed %b, expected %b", tag, fl, m_flags);
    end
    n_cmp++;
    assert ($countones({sig_SUMS, sig_ANDS, sig_EORS, sig_ORS, sig_SRS}) <= 1) else begin
      n_err++;
      $error("FAIL %s select_onehot: observed %b, expected at most one bit", tag,
             {sig_SUMS, sig_ANDS, sig_EORS, sig_ORS, sig_SRS});
    end
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic run_op(input logic [2:0] o, input logic c, input logic d, input bit poke,
                        input bit hold, input bit rnd_alu, input logic [2:0] fix_alu);
    int ph[$];
    logic [2:0] cap;
    bit got;
    ph.push_back(PH_LA);
    if (!(o == 3'd5 || o == 3'd6)) ph.push_back(PH_LB);
    repeat (EC) ph.push_back(PH_EX);
    ph.push_back(PH_HO);
    ph.push_back(PH_WR);
    op = o; c_flag = c; d_flag = d; start = 1'b1;
    @(posedge CLK); #1;
    if (!hold) start = 1'b0;
    foreach (ph[i]) begin
      if (rnd_alu) {ACR_OUT, AVR_OUT, HC_OUT} = 3'($urandom);
      else         {ACR_OUT, AVR_OUT, HC_OUT} = fix_alu;
      if (poke && i == 1) begin
        start = 1'b1; op = 3'($urandom); c_flag = 1'($urandom); d_flag = 1'($urandom);
      end
      if (poke && i == 2) start = 1'b0;
      got = (i == ph.size() - 3);
      cap = {ACR_OUT, AVR_OUT, DecEn ? HC_OUT : 1'b0};
      @(negedge CLK);
      check_cycle($sformatf("op%0d_c%0d_d%0d_cyc%0d", o, c, d, i + 1), model(ph[i], o, c, d));
      @(posedge CLK); #1;
      if (got) m_flags = cap;
    end
    if (!hold) begin
      @(negedge CLK);
      check_cycle($sformatf("op%0d_idle", o), '0);
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_cycle("reset", '0);
    @(posedge CLK); #1;
    RST = 1'b0;

    run_op(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100);  // ADC, ACR=1 AVR=0
    run_op(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000);  // SBC
    run_op(3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000);  // LSR
    run_op(3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000);  // ROR
    run_op(3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b111);  // ADDR

    // RST in EXEC of an ADC
    op = 3'd0; c_flag = 1'b1; d_flag = 1'b0; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (2) begin
      @(posedge CLK); #1;
    end
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    m_flags = 3'b000;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check_cycle($sformatf("after_rst_%0d", i), '0);
      @(posedge CLK); #1;
    end
    run_op(3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000);  // AND after reset

    run_op(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b011);  // ADC decimal, HC=1
    run_op(3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000);  // SBC decimal
    run_op(3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000);  // ORA, start poked while busy

    // start held across done: re-accepted straight from the IDLE cycle
    run_op(3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000);
    run_op(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000);

    for (int k = 0; k < 24; k++) begin
      run_op(3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b1, 3'b000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
